// File: rtl/game_flow_controller.sv
// Top-level game sequencer: IDLE / PLAY / TRANSITION / GAME_OVER flow, lives
// and per-level countdown, with the reset pulses for the hero, enemy and score blocks.
module game_flow_controller #(
    parameter int LIVES_INIT     = 3,
    parameter int FRAMES_PER_SEC = 60,
    parameter int TIME_LIMIT     = 99,
    parameter int PAUSE_FRAMES   = 120,
    parameter int MAX_LEVEL      = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       frame_tick,
    input  logic       level_up,
    input  logic [3:0] level,
    input  logic       hero_hit,
    output logic [1:0] state,
    output logic       play_en,
    output logic       hero_rst,
    output logic       game_rst,
    output logic [1:0] lives,
    output logic [6:0] time_left,
    output logic       win
);

    localparam int FRAME_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int PAUSE_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_FRAMES - 1);
    localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);
    localparam logic [6:0]         TIME_LOAD  = 7'(TIME_LIMIT);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PLAY       = 2'd1,
        TRANSITION = 2'd2,
        GAME_OVER  = 2'd3
    } state_t;

    state_t             state_q;
    logic               start_q;
    logic [FRAME_W-1:0] frame_cnt;
    logic [PAUSE_W-1:0] pause_cnt;

    logic start_edge;
    logic timeout;
    logic final_level;
    logic last_life;

    assign start_edge  = start_btn & ~start_q;
    assign timeout     = (time_left == 7'd0);
    assign final_level = (int'(level) >= MAX_LEVEL);
    assign last_life   = (lives == 2'd1);
    assign state       = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            frame_cnt <= '0;
            pause_cnt <= '0;
            play_en   <= 1'b0;
            hero_rst  <= 1'b0;
            game_rst  <= 1'b0;
            lives     <= LIVES_LOAD;
            time_left <= TIME_LOAD;
            win       <= 1'b0;
        end else begin
            start_q  <= start_btn;
            // NOTE: pulses default low every cycle and are raised only by the
            // transitions below, so they can never stretch past one cycle.
            hero_rst <= 1'b0;
            game_rst <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_q   <= PLAY;
                        play_en   <= 1'b1;
                        game_rst  <= 1'b1;
                        hero_rst  <= 1'b1;
                        lives     <= LIVES_LOAD;
                        time_left <= TIME_LOAD;
                        win       <= 1'b0;
                        frame_cnt <= '0;
                    end
                end

                PLAY: begin
                    // level_up outranks hero_hit, which outranks timeout.
                    if (level_up) begin
                        play_en <= 1'b0;
                        if (final_level) begin
                            state_q <= GAME_OVER;
                            win     <= 1'b1;
                        end else begin
                            state_q   <= TRANSITION;
                            hero_rst  <= 1'b1;
                            pause_cnt <= '0;
                        end
                    end else if (hero_hit || timeout) begin
                        play_en <= 1'b0;
                        if (last_life) begin
                            state_q <= GAME_OVER;
                            lives   <= 2'd0;
                            win     <= 1'b0;
                        end else begin
                            state_q   <= TRANSITION;
                            lives     <= lives - 2'd1;
                            hero_rst  <= 1'b1;
                            pause_cnt <= '0;
                        end
                    end else if (frame_tick) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt <= '0;
                            if (time_left != 7'd0) begin
                                time_left <= time_left - 7'd1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                TRANSITION: begin
                    if (frame_tick) begin
                        if (pause_cnt == PAUSE_LAST) begin
                            state_q   <= PLAY;
                            play_en   <= 1'b1;
                            time_left <= TIME_LOAD;
                            frame_cnt <= '0;
                            pause_cnt <= '0;
                        end else begin
                            pause_cnt <= pause_cnt + 1'b1;
                        end
                    end
                end

                GAME_OVER: begin
                    // win is only meaningful while the game-over screen is shown.
                    if (start_edge) begin
                        state_q <= IDLE;
                        win     <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    play_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed and randomized checks of game_flow_controller against a tick-counting
// reference model of the game rules.
module tb_game_flow_controller;

    localparam int LIVES_INIT     = 3;
    localparam int FRAMES_PER_SEC = 60;
    localparam int TIME_LIMIT     = 99;
    localparam int PAUSE_FRAMES   = 120;
    localparam int MAX_LEVEL      = 9;

    localparam int ST_IDLE  = 0;
    localparam int ST_PLAY  = 1;
    localparam int ST_TRANS = 2;
    localparam int ST_OVER  = 3;

    logic       clk;
    logic       rst_n;
    logic       start_btn;
    logic       frame_tick;
    logic       level_up;
    logic [3:0] level;
    logic       hero_hit;
    logic [1:0] state;
    logic       play_en;
    logic       hero_rst;
    logic       game_rst;
    logic [1:0] lives;
    logic [6:0] time_left;
    logic       win;

    game_flow_controller #(
        .LIVES_INIT    (LIVES_INIT),
        .FRAMES_PER_SEC(FRAMES_PER_SEC),
        .TIME_LIMIT    (TIME_LIMIT),
        .PAUSE_FRAMES  (PAUSE_FRAMES),
        .MAX_LEVEL     (MAX_LEVEL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_btn (start_btn),
        .frame_tick(frame_tick),
        .level_up  (level_up),
        .level     (level),
        .hero_hit  (hero_hit),
        .state     (state),
        .play_en   (play_en),
        .hero_rst  (hero_rst),
        .game_rst  (game_rst),
        .lives     (lives),
        .time_left (time_left),
        .win       (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: game phase, lives, and ticks counted since the level began.
    int m_state;
    int m_lives;
    int m_play_ticks;
    int m_pause;
    bit m_win;
    bit m_btn_q;
    bit e_hero_rst;
    bit e_game_rst;

    function automatic int exp_time();
        int secs;
        secs = m_play_ticks / FRAMES_PER_SEC;
        return (secs >= TIME_LIMIT) ? 0 : TIME_LIMIT - secs;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("state",     32'(state),     32'(m_state));
        check("play_en",   32'(play_en),   32'(m_state == ST_PLAY));
        check("hero_rst",  32'(hero_rst),  32'(e_hero_rst));
        check("game_rst",  32'(game_rst),  32'(e_game_rst));
        check("lives",     32'(lives),     32'(m_lives));
        check("time_left", 32'(time_left), 32'(exp_time()));
        check("win",       32'(win),       32'(m_win));
    endtask

    task automatic model_reset();
        m_state      = ST_IDLE;
        m_lives      = LIVES_INIT;
        m_play_ticks = 0;
        m_pause      = 0;
        m_win        = 1'b0;
        m_btn_q      = 1'b0;
        e_hero_rst   = 1'b0;
        e_game_rst   = 1'b0;
    endtask

    // One clock cycle. A frame tick is withheld on cycles where the phase changes,
    // so every counted tick belongs unambiguously to one phase.
    task automatic step(input bit btn, input bit tick, input bit lu,
                        input logic [3:0] lvl, input bit hit);
        bit edge_now;
        bit leaving;
        edge_now = btn && !m_btn_q;
        leaving  = ((m_state == ST_IDLE || m_state == ST_OVER) && edge_now) ||
                   (m_state == ST_PLAY && (lu || hit || exp_time() == 0));
        if (leaving) tick = 1'b0;

        start_btn  = btn;
        frame_tick = tick;
        level_up   = lu;
        level      = lvl;
        hero_hit   = hit;
        @(posedge clk);

        e_hero_rst = 1'b0;
        e_game_rst = 1'b0;
        case (m_state)
            ST_IDLE: begin
                if (edge_now) begin
                    m_state      = ST_PLAY;
                    e_game_rst   = 1'b1;
                    e_hero_rst   = 1'b1;
                    m_lives      = LIVES_INIT;
                    m_play_ticks = 0;
                    m_win        = 1'b0;
                end
            end
            ST_PLAY: begin
                if (lu) begin
                    if (int'(lvl) >= MAX_LEVEL) begin
                        m_state = ST_OVER;
                        m_win   = 1'b1;
                    end else begin
                        m_state    = ST_TRANS;
                        m_pause    = 0;
                        e_hero_rst = 1'b1;
                    end
                end else if (hit || exp_time() == 0) begin
                    if (m_lives == 1) begin
                        m_state = ST_OVER;
                        m_lives = 0;
                        m_win   = 1'b0;
                    end else begin
                        m_lives    = m_lives - 1;
                        m_state    = ST_TRANS;
                        m_pause    = 0;
                        e_hero_rst = 1'b1;
                    end
                end else if (tick) begin
                    m_play_ticks++;
                end
            end
            ST_TRANS: begin
                if (tick) begin
                    m_pause++;
                    if (m_pause == PAUSE_FRAMES) begin
                        m_state      = ST_PLAY;
                        m_play_ticks = 0;
                        m_pause      = 0;
                    end
                end
            end
            default: begin
                if (edge_now) begin
                    m_state = ST_IDLE;
                    m_win   = 1'b0;
                end
            end
        endcase
        m_btn_q = btn;

        #1;
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    endtask

    task automatic tick_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
    endtask

    initial begin
        int pulses_game;
        int pulses_hero;
        int guard;
        bit rbtn;

        rst_n      = 1'b0;
        start_btn  = 1'b0;
        frame_tick = 1'b0;
        level_up   = 1'b0;
        level      = 4'd1;
        hero_hit   = 1'b0;
        model_reset();

        // Reset state.
        @(posedge clk);
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(2);
        check("reset_state", 32'(state), 32'd0);

        // Start: button held 5 cycles gives exactly one game_rst and one hero_rst.
        pulses_game = 0;
        pulses_hero = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
            pulses_game += int'(game_rst);
            pulses_hero += int'(hero_rst);
        end
        check("start_game_rst_count", 32'(pulses_game), 32'd1);
        check("start_hero_rst_count", 32'(pulses_hero), 32'd1);
        check("start_state", 32'(state), 32'd1);
        check("start_lives", 32'(lives), 32'd3);
        check("start_time", 32'(time_left), 32'd99);
        check("start_play_en", 32'(play_en), 32'd1);
        idle_cycles(3);

        // Countdown: one second of ticks, then run to zero and time out.
        tick_cycles(60);
        check("one_second", 32'(time_left), 32'd98);
        guard = 0;
        while (exp_time() != 0 && guard < 7000) begin
            step(1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
            guard++;
        end
        check("countdown_bound", 32'(guard < 7000), 32'd1);
        check("time_zero", 32'(time_left), 32'd0);
        check("still_play_at_zero", 32'(state), 32'd1);
        step(1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
        check("timeout_lives", 32'(lives), 32'd2);
        check("timeout_state", 32'(state), 32'd2);
        check("timeout_hero_rst", 32'(hero_rst), 32'd1);
        tick_cycles(119);
        check("pause_not_done", 32'(state), 32'd2);
        tick_cycles(1);
        check("pause_done_state", 32'(state), 32'd1);
        check("pause_done_time", 32'(time_left), 32'd99);

        // Simultaneous level_up and hero_hit: level_up wins, lives kept.
        step(1'b0, 1'b0, 1'b1, 4'd3, 1'b1);
        check("simul_state", 32'(state), 32'd2);
        check("simul_lives", 32'(lives), 32'd2);
        check("simul_hero_rst", 32'(hero_rst), 32'd1);
        step(1'b0, 1'b0, 1'b0, 4'd3, 1'b1);
        check("simul_single_pulse", 32'(hero_rst), 32'd0);
        check("trans_ignores_hit", 32'(lives), 32'd2);
        tick_cycles(PAUSE_FRAMES);

        // Loss: two hits take the last lives.
        step(1'b0, 1'b0, 1'b0, 4'd3, 1'b1);
        check("hit_lives", 32'(lives), 32'd1);
        tick_cycles(PAUSE_FRAMES);
        step(1'b0, 1'b0, 1'b0, 4'd3, 1'b1);
        check("loss_state", 32'(state), 32'd3);
        check("loss_lives", 32'(lives), 32'd0);
        check("loss_win", 32'(win), 32'd0);
        check("loss_play_en", 32'(play_en), 32'd0);
        idle_cycles(3);
        step(1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
        check("loss_to_idle", 32'(state), 32'd0);
        step(1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
        check("held_btn_stays_idle", 32'(state), 32'd0);

        // Win: new game, level_up at MAX_LEVEL.
        step(1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
        check("new_game_game_rst", 32'(game_rst), 32'd1);
        check("new_game_lives", 32'(lives), 32'd3);
        tick_cycles(70);
        step(1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
        check("win_state", 32'(state), 32'd3);
        check("win_flag", 32'(win), 32'd1);
        check("win_no_hero_rst", 32'(hero_rst), 32'd0);
        check("win_time_hold", 32'(time_left), 32'd98);
        idle_cycles(2);
        step(1'b1, 1'b0, 1'b0, 4'd9, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        check("pre_reset_state", 32'(state), 32'd2);
        tick_cycles(10);

        // Asynchronous reset in TRANSITION, checked before the next clock edge.
        rst_n = 1'b0;
        start_btn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        idle_cycles(2);

        // Randomized play against the model.
        rbtn = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 15) == 0) rbtn = ~rbtn;
            step(rbtn,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0),
                 4'($urandom_range(1, 12)),
                 1'($urandom_range(0, 29) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
